rhythm_game_flow_ctrl: RTL and testbench

RHYTHM_GAME_FLOW_CTRL -- requirements
Module: rhythm_game_flow_ctrl

---
 rtl/rhythm_game_flow_ctrl_if.sv | 36 +++
 rtl/rhythm_game_flow_ctrl.sv | 180 ++++++++++++++++++
 tb/tb_rhythm_game_flow_ctrl.sv | 259 +++++++++++++++++++++++++
 3 files changed

// File: rtl/rhythm_game_flow_ctrl_if.sv
// Signal bundle between the rhythm-game flow controller and the rest of the game.
// The slave modport is the controller's view, the master modport the driving side.
interface rhythm_game_flow_ctrl_if #(
  parameter int NUM_TRACKS = 2,
  parameter int TIME_W     = 32,
  parameter int SCORE_W    = 16
);
  logic                      i_tick;
  logic                      i_start;
  logic                      i_restart;
  logic                      i_pause;
  logic                      i_song_end;
  logic [NUM_TRACKS-1:0]     i_judge_vld;
  logic [2*NUM_TRACKS-1:0]   i_judge;
  logic [2:0]                o_state;
  logic                      o_game_start;
  logic                      o_gated_tick;
  logic [TIME_W-1:0]         o_cur_time;
  logic [15:0]               o_cd_remain;
  logic [SCORE_W-1:0]        o_score;
  logic [15:0]               o_combo;
  logic [15:0]               o_max_combo;
  logic                      o_game_over;

  modport master (
    output i_tick, i_start, i_restart, i_pause, i_song_end, i_judge_vld, i_judge,
    input  o_state, o_game_start, o_gated_tick, o_cur_time, o_cd_remain,
           o_score, o_combo, o_max_combo, o_game_over
  );

  modport slave (
    input  i_tick, i_start, i_restart, i_pause, i_song_end, i_judge_vld, i_judge,
    output o_state, o_game_start, o_gated_tick, o_cur_time, o_cd_remain,
           o_score, o_combo, o_max_combo, o_game_over
  );
endinterface

// File: rtl/rhythm_game_flow_ctrl.sv
// Game flow controller: IDLE -> COUNTDOWN -> PLAY -> END with score/combo/time keeping.
// Define FLOW_PAUSE_EN to enable the PLAY<->PAUSE toggle on i_pause.
module rhythm_game_flow_ctrl #(
  parameter int NUM_TRACKS   = 2,
  parameter int TIME_W       = 32,
  parameter int SCORE_W      = 16,
  parameter int COUNTDOWN_MS = 3000,
  parameter int PERF_PTS     = 2,
  parameter int NORM_PTS     = 1
) (
  input logic                    clk,
  input logic                    rst,
  rhythm_game_flow_ctrl_if.slave bus
);

`ifdef FLOW_PAUSE_EN
  localparam bit PAUSE_EN = 1'b1;
`else
  localparam bit PAUSE_EN = 1'b0;
`endif

  localparam int          SUM_W   = SCORE_W + 21;
  localparam logic [15:0] CD_LOAD = 16'(COUNTDOWN_MS);

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_COUNTDOWN = 3'd1,
    ST_PLAY      = 3'd2,
    ST_PAUSE     = 3'd3,
    ST_END       = 3'd4
  } state_t;

  state_t               state_reg, state_next;
  logic [15:0]          cd_reg, cd_next;
  logic [TIME_W-1:0]    time_reg, time_next;
  logic [SCORE_W-1:0]   score_reg, score_next;
  logic [15:0]          combo_reg, combo_next;
  logic [15:0]          max_reg, max_next;

  logic in_play, gated_tick, restart_act, start_act, pause_req;

  assign in_play     = (state_reg == ST_PLAY);
  assign gated_tick  = bus.i_tick && in_play;
  assign restart_act = bus.i_restart && (state_reg != ST_IDLE);
  assign start_act   = bus.i_start && (state_reg == ST_IDLE);
  assign pause_req   = PAUSE_EN && bus.i_pause;

  // Per-track judgement decode: code 01 is a miss, 1x is a hit (bit 0 selects perfect).
  logic [NUM_TRACKS-1:0] trk_hit, trk_miss;
  logic [15:0]           trk_pts [NUM_TRACKS];

  for (genvar gi = 0; gi < NUM_TRACKS; gi++) begin : g_trk
    logic [1:0] code;
    assign code         = bus.i_judge[2*gi+1 -: 2];
    assign trk_miss[gi] = bus.i_judge_vld[gi] && (code == 2'b01);
    assign trk_hit[gi]  = bus.i_judge_vld[gi] && code[1];
    assign trk_pts[gi]  = !trk_hit[gi] ? 16'd0 :
                          (code[0] ? 16'(PERF_PTS) : 16'(NORM_PTS));
  end

  logic [19:0]        pts_sum;
  logic [3:0]         hit_cnt;
  logic [SUM_W-1:0]   score_sum;
  logic [SCORE_W-1:0] score_sat;
  logic [16:0]        combo_sum;
  logic [15:0]        combo_new;

  always_comb begin
    pts_sum = '0;
    hit_cnt = '0;
    for (int k = 0; k < NUM_TRACKS; k++) begin
      pts_sum = pts_sum + 20'(trk_pts[k]);
      hit_cnt = hit_cnt + 4'(trk_hit[k]);
    end
  end

  always_comb begin
    score_sum = SUM_W'(score_reg) + SUM_W'(pts_sum);
    score_sat = (|score_sum[SUM_W-1:SCORE_W]) ? '1 : score_sum[SCORE_W-1:0];
    combo_sum = {1'b0, combo_reg} + 17'(hit_cnt);
    // A miss anywhere in the cycle wins over any hits on other tracks.
    if (|trk_miss) begin
      combo_new = '0;
    end else if (combo_sum[16]) begin
      combo_new = 16'hFFFF;
    end else begin
      combo_new = combo_sum[15:0];
    end
  end

  // State register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg <= ST_IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // Next-state logic; restart overrides every other request
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ST_IDLE:      if (bus.i_start) state_next = ST_COUNTDOWN;
      ST_COUNTDOWN: if (cd_reg == 16'd0) state_next = ST_PLAY;
      ST_PLAY: begin
        if (bus.i_song_end) begin
          state_next = ST_END;
        end else if (pause_req) begin
          state_next = ST_PAUSE;
        end
      end
      ST_PAUSE:     if (pause_req) state_next = ST_PLAY;
      ST_END:       state_next = ST_END;
      default:      state_next = ST_IDLE;
    endcase
    if (restart_act) begin
      state_next = ST_COUNTDOWN;
    end
  end

  // Output logic
  always_comb begin
    bus.o_state      = state_reg;
    bus.o_game_start = (state_reg == ST_PLAY) || (state_reg == ST_PAUSE);
    bus.o_game_over  = (state_reg == ST_END);
    bus.o_gated_tick = gated_tick;
  end

  // Game progress datapath
  always_comb begin
    cd_next    = cd_reg;
    time_next  = time_reg;
    score_next = score_reg;
    combo_next = combo_reg;
    max_next   = max_reg;
    if (restart_act || start_act) begin
      cd_next    = CD_LOAD;
      time_next  = '0;
      score_next = '0;
      combo_next = '0;
      max_next   = '0;
    end else begin
      if ((state_reg == ST_COUNTDOWN) && bus.i_tick && (cd_reg != 16'd0)) begin
        cd_next = cd_reg - 16'd1;
      end
      if (gated_tick && (time_reg != '1)) begin
        time_next = time_reg + TIME_W'(1);
      end
      if (in_play) begin
        score_next = score_sat;
        combo_next = combo_new;
        max_next   = (combo_new > max_reg) ? combo_new : max_reg;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cd_reg    <= '0;
      time_reg  <= '0;
      score_reg <= '0;
      combo_reg <= '0;
      max_reg   <= '0;
    end else begin
      cd_reg    <= cd_next;
      time_reg  <= time_next;
      score_reg <= score_next;
      combo_reg <= combo_next;
      max_reg   <= max_next;
    end
  end

  assign bus.o_cd_remain = cd_reg;
  assign bus.o_cur_time  = time_reg;
  assign bus.o_score     = score_reg;
  assign bus.o_combo     = combo_reg;
  assign bus.o_max_combo = max_reg;

endmodule

// File: tb/tb_rhythm_game_flow_ctrl.sv
// Self-checking bench for rhythm_game_flow_ctrl: directed scenarios plus random
// stimulus, all outputs compared every cycle against a behavioural game model.
module tb_rhythm_game_flow_ctrl;

`ifdef FLOW_PAUSE_EN
  localparam bit PAUSE_EN = 1'b1;
`else
  localparam bit PAUSE_EN = 1'b0;
`endif

  localparam int      CD_MS = 5;
  localparam int      PERF  = 2;
  localparam int      NORM  = 1;
  localparam longint  TMAX  = 64'hFFFF_FFFF;
  localparam longint  SMAX  = 65535;
  localparam longint  CMAX  = 65535;

  logic clk;
  logic rst;

  rhythm_game_flow_ctrl_if #(.NUM_TRACKS(2), .TIME_W(32), .SCORE_W(16)) bus ();

  rhythm_game_flow_ctrl #(
    .NUM_TRACKS(2), .TIME_W(32), .SCORE_W(16),
    .COUNTDOWN_MS(CD_MS), .PERF_PTS(PERF), .NORM_PTS(NORM)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int n_cmp = 0;
  int n_bad = 0;

  // Game model: 0 idle, 1 countdown, 2 play, 3 pause, 4 end
  int     m_state;
  longint m_cd, m_time, m_score, m_combo, m_max;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic void model_reset();
    m_state = 0; m_cd = 0; m_time = 0; m_score = 0; m_combo = 0; m_max = 0;
  endfunction

  function automatic void model_new_game();
    m_state = 1; m_cd = CD_MS; m_time = 0; m_score = 0; m_combo = 0; m_max = 0;
  endfunction

  function automatic void model_step(input bit t, s, r, p, e,
                                     input logic [1:0] v, input logic [3:0] j);
    int pts;
    int hits;
    bit miss;
    logic [1:0] code;
    pts = 0; hits = 0; miss = 1'b0;
    if (r && m_state != 0) begin
      model_new_game();
      return;
    end
    case (m_state)
      0: if (s) model_new_game();
      1: begin
        if (m_cd == 0) m_state = 2;
        else if (t) m_cd = m_cd - 1;
      end
      2: begin
        for (int k = 0; k < 2; k++) begin
          code = j[2*k +: 2];
          if (v[k]) begin
            if (code == 2'b01) miss = 1'b1;
            else if (code == 2'b10) begin pts += NORM; hits++; end
            else if (code == 2'b11) begin pts += PERF; hits++; end
          end
        end
        if (t && m_time < TMAX) m_time = m_time + 1;
        m_score = (m_score + pts > SMAX) ? SMAX : m_score + pts;
        if (miss) m_combo = 0;
        else m_combo = (m_combo + hits > CMAX) ? CMAX : m_combo + hits;
        if (m_combo > m_max) m_max = m_combo;
        if (e) m_state = 4;
        else if (PAUSE_EN && p) m_state = 3;
      end
      3: if (PAUSE_EN && p) m_state = 2;
      default: ;
    endcase
  endfunction

  task automatic check_all();
    chk("state",      64'(bus.o_state),      64'(m_state));
    chk("game_start", 64'(bus.o_game_start), 64'(m_state == 2 || m_state == 3));
    chk("gated_tick", 64'(bus.o_gated_tick), 64'(bus.i_tick && m_state == 2));
    chk("cur_time",   64'(bus.o_cur_time),   64'(m_time));
    chk("cd_remain",  64'(bus.o_cd_remain),  64'(m_cd));
    chk("score",      64'(bus.o_score),      64'(m_score));
    chk("combo",      64'(bus.o_combo),      64'(m_combo));
    chk("max_combo",  64'(bus.o_max_combo),  64'(m_max));
    chk("game_over",  64'(bus.o_game_over),  64'(m_state == 4));
  endtask

  // One clock cycle: drive, compare at the falling edge, advance the model on the rising edge.
  task automatic cyc(input bit t, s, r, p, e, input logic [1:0] v, input logic [3:0] j);
    bus.i_tick = t; bus.i_start = s; bus.i_restart = r; bus.i_pause = p;
    bus.i_song_end = e; bus.i_judge_vld = v; bus.i_judge = j;
    @(negedge clk);
    check_all();
    @(posedge clk);
    model_step(t, s, r, p, e, v, j);
    #1;
  endtask

  task automatic idle();
    cyc(0, 0, 0, 0, 0, 2'b00, 4'b0000);
  endtask

  task automatic tick();
    cyc(1, 0, 0, 0, 0, 2'b00, 4'b0000);
  endtask

  task automatic zero_inputs();
    bus.i_tick = 0; bus.i_start = 0; bus.i_restart = 0; bus.i_pause = 0;
    bus.i_song_end = 0; bus.i_judge_vld = '0; bus.i_judge = '0;
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, "_state"}, 64'(bus.o_state), 0);
    chk({tag, "_start"}, 64'(bus.o_game_start), 0);
    chk({tag, "_gtick"}, 64'(bus.o_gated_tick), 0);
    chk({tag, "_time"},  64'(bus.o_cur_time), 0);
    chk({tag, "_cd"},    64'(bus.o_cd_remain), 0);
    chk({tag, "_score"}, 64'(bus.o_score), 0);
    chk({tag, "_combo"}, 64'(bus.o_combo), 0);
    chk({tag, "_max"},   64'(bus.o_max_combo), 0);
    chk({tag, "_over"},  64'(bus.o_game_over), 0);
  endtask

  initial begin
    longint saved_time, saved_score;
    rst = 1'b0;
    zero_inputs();
    model_reset();
    #12;
    check_all_zero("reset");
    @(posedge clk);
    #1;
    rst = 1'b1;

    // Countdown: 5..0 in COUNTDOWN, then PLAY, gated tick only on the 6th tick
    cyc(0, 1, 0, 0, 0, 2'b00, 4'b0000);
    chk("cd_load_state", 64'(bus.o_state), 1);
    chk("cd_load", 64'(bus.o_cd_remain), 5);
    for (int i = 1; i <= 5; i++) begin
      bus.i_tick = 1'b1;
      #1;
      chk("gated_in_cd", 64'(bus.o_gated_tick), 0);
      tick();
      chk("cd_step", 64'(bus.o_cd_remain), 64'(5 - i));
      chk("cd_state", 64'(bus.o_state), 1);
    end
    idle();
    chk("enter_play", 64'(bus.o_state), 2);
    bus.i_tick = 1'b1;
    #1;
    chk("gated_6th", 64'(bus.o_gated_tick), 1);
    tick();
    chk("time_first", 64'(bus.o_cur_time), 1);

    // Mixed normal + perfect hit
    cyc(0, 0, 0, 0, 0, 2'b11, 4'b1110);
    chk("mix_score", 64'(bus.o_score), 3);
    chk("mix_combo", 64'(bus.o_combo), 2);

    // Build combo to 7, then a miss on one track clears it
    for (int i = 0; i < 5; i++) cyc(0, 0, 0, 0, 0, 2'b01, 4'b0011);
    chk("combo7", 64'(bus.o_combo), 7);
    cyc(0, 0, 0, 0, 0, 2'b11, 4'b0111);
    chk("miss_combo", 64'(bus.o_combo), 0);
    chk("miss_max", 64'(bus.o_max_combo), 7);
    chk("miss_score", 64'(bus.o_score), 15);

    // Pause at time 100 (ignored when pause support is compiled out)
    for (int i = 0; i < 99; i++) tick();
    chk("time100", 64'(bus.o_cur_time), 100);
    cyc(0, 0, 0, 1, 0, 2'b00, 4'b0000);
    chk("pause_state", 64'(bus.o_state), PAUSE_EN ? 3 : 2);
    for (int i = 0; i < 50; i++) tick();
    chk("pause_time", 64'(bus.o_cur_time), PAUSE_EN ? 100 : 150);
    cyc(0, 0, 0, 0, 0, 2'b11, 4'b1111);
    chk("pause_score", 64'(bus.o_score), PAUSE_EN ? 15 : 19);
    cyc(0, 0, 0, 1, 0, 2'b00, 4'b0000);
    chk("resume_state", 64'(bus.o_state), 2);
    tick();
    chk("resume_time", 64'(bus.o_cur_time), PAUSE_EN ? 101 : 151);

    // Song end freezes progress; restart beats start
    cyc(0, 0, 0, 0, 1, 2'b00, 4'b0000);
    chk("end_over", 64'(bus.o_game_over), 1);
    saved_time = m_time;
    saved_score = m_score;
    cyc(1, 0, 0, 0, 0, 2'b11, 4'b1111);
    chk("end_time_frozen", 64'(bus.o_cur_time), 64'(saved_time));
    chk("end_score_frozen", 64'(bus.o_score), 64'(saved_score));
    cyc(0, 1, 1, 0, 0, 2'b00, 4'b0000);
    chk("restart_state", 64'(bus.o_state), 1);
    chk("restart_score", 64'(bus.o_score), 0);
    chk("restart_max", 64'(bus.o_max_combo), 0);
    chk("restart_cd", 64'(bus.o_cd_remain), 5);

    // Saturation of score and combo under continuous double-perfect hits
    for (int i = 0; i < 5; i++) tick();
    idle();
    for (int i = 0; i < 32800; i++) cyc(0, 0, 0, 0, 0, 2'b11, 4'b1111);
    chk("sat_score", 64'(bus.o_score), 65535);
    chk("sat_combo", 64'(bus.o_combo), 65535);
    chk("sat_max", 64'(bus.o_max_combo), 65535);
    cyc(0, 0, 0, 0, 0, 2'b11, 4'b0101);
    chk("sat_miss_combo", 64'(bus.o_combo), 0);
    chk("sat_miss_max", 64'(bus.o_max_combo), 65535);

    // Random stimulus against the model
    for (int i = 0; i < 3000; i++) begin
      cyc(($urandom % 3) == 0, ($urandom % 8) == 0, ($urandom % 64) == 0,
          ($urandom % 40) == 0, ($urandom % 100) == 0,
          2'($urandom), 4'($urandom));
    end

    // Asynchronous reset in the middle of PLAY with score 40
    cyc(0, 1, 1, 0, 0, 2'b00, 4'b0000);
    for (int i = 0; i < 5; i++) tick();
    idle();
    for (int i = 0; i < 10; i++) cyc(0, 0, 0, 0, 0, 2'b11, 4'b1111);
    chk("pre_rst_score", 64'(bus.o_score), 40);
    zero_inputs();
    rst = 1'b0;
    #1;
    check_all_zero("async_rst");
    model_reset();
    @(posedge clk);
    #1;
    rst = 1'b1;
    cyc(0, 1, 0, 0, 0, 2'b00, 4'b0000);
    chk("post_rst_start", 64'(bus.o_state), 1);
    idle();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
